// File: rtl/morse_pkg.sv
// Shared constants, state encoding and letter decoder for the Morse receiver.
package morse_pkg;

   // Default clock cycles per Morse unit: 0.5 s at 50 MHz.
   localparam int unsigned DEF_TICK_COUNT = 25_000_000;

   // Letter codes of the lab alphabet.
   localparam logic [2:0] LETTER_S = 3'd0;
   localparam logic [2:0] LETTER_T = 3'd1;
   localparam logic [2:0] LETTER_U = 3'd2;
   localparam logic [2:0] LETTER_V = 3'd3;
   localparam logic [2:0] LETTER_W = 3'd4;
   localparam logic [2:0] LETTER_X = 3'd5;
   localparam logic [2:0] LETTER_Y = 3'd6;
   localparam logic [2:0] LETTER_Z = 3'd7;

   // Symbol encodings in the shift register.
   localparam logic DOT  = 1'b0;
   localparam logic DASH = 1'b1;

   // Run lengths in units.
   localparam logic [2:0] MARK_DOT   = 3'd1;
   localparam logic [2:0] MARK_DASH  = 3'd3;
   localparam logic [2:0] MARK_SAT   = 3'd4;
   localparam logic [1:0] GAP_LETTER = 2'd3;
   localparam logic [2:0] MAX_SYMS   = 3'd4;

   typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

   typedef struct packed {
      logic       match;
      logic [2:0] code;
   } decode_t;

   // Symbols enter at bit 0, so the first symbol ends up in the highest used bit
   // and unused upper bits stay zero.
   function automatic decode_t decode_letter(input logic [2:0] nsym, input logic [3:0] sym);
      decode_t d;
      d.match = 1'b1;
      d.code  = LETTER_S;
      case ({nsym, sym})
         {3'd3, 4'b0000}: d.code = LETTER_S;
         {3'd1, 4'b0001}: d.code = LETTER_T;
         {3'd3, 4'b0001}: d.code = LETTER_U;
         {3'd4, 4'b0001}: d.code = LETTER_V;
         {3'd3, 4'b0011}: d.code = LETTER_W;
         {3'd4, 4'b1001}: d.code = LETTER_X;
         {3'd4, 4'b1011}: d.code = LETTER_Y;
         {3'd4, 4'b1100}: d.code = LETTER_Z;
         default:         d.match = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/morse_receiver_if.sv
// Decoded-letter output bundle of the Morse receiver.
interface morse_receiver_if;
   logic [2:0] letter;
   logic       letter_valid;
   logic       letter_error;
   logic       busy;

   modport master (output letter, letter_valid, letter_error, busy);
   modport slave  (input  letter, letter_valid, letter_error, busy);
endinterface

// File: rtl/morse_tick_gen.sv
// Unit-rate divider: one-cycle tick every TICK_COUNT enabled cycles, with a
// half-period load used to centre ticks inside a unit.
module morse_tick_gen
   import morse_pkg::*;
#(
   parameter int unsigned TICK_COUNT = DEF_TICK_COUNT
) (
   input  logic clock,
   input  logic reset_n,
   input  logic i_enable,
   input  logic i_half_load,
   output logic o_tick
);

   localparam int unsigned   CW     = $clog2(TICK_COUNT);
   localparam logic [CW-1:0] RELOAD = CW'(TICK_COUNT - 1);
   localparam logic [CW-1:0] HALF   = CW'(TICK_COUNT / 2);

   logic [CW-1:0] r_cnt;

   assign o_tick = i_enable && (r_cnt == '0);

   // Down-count while enabled; reload on zero, half-load on request.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_cnt <= RELOAD;
      end else if (i_enable) begin
         if (i_half_load)      r_cnt <= HALF;
         else if (r_cnt == '0) r_cnt <= RELOAD;
         else                  r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/morse_receiver.sv
// Morse receiver: samples the key once per unit, classifies marks and gaps and
// reports one decoded letter (or an error) per letter gap.
module morse_receiver
   import morse_pkg::*;
#(
   parameter int unsigned TICK_COUNT = DEF_TICK_COUNT
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    i_enable,
   input  logic                    i_key_in,
   morse_receiver_if.master        o_rx
);

   logic       r_key_meta, r_key_s, r_key_prev;
   state_t     r_state;
   logic [2:0] r_mcnt;
   logic [1:0] r_scnt;
   logic [3:0] r_sym;
   logic [2:0] r_nsym;
   logic       r_err;
   logic [2:0] r_letter;
   logic       r_letter_valid, r_letter_error;

   logic       w_tick, w_rise, w_half_load;
   logic       w_mark_ok, w_full, w_sym_bit;
   decode_t    w_dec;

   // Two-flop synchronizer plus edge history; runs even while disabled so that
   // edges occurring while frozen are consumed and never seen later.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_key_meta <= 1'b0;
         r_key_s    <= 1'b0;
         r_key_prev <= 1'b0;
      end else begin
         r_key_meta <= i_key_in;
         r_key_s    <= r_key_meta;
         r_key_prev <= r_key_s;
      end
   end

   assign w_rise      = r_key_s && !r_key_prev;
   assign w_half_load = i_enable && (r_state == IDLE) && w_rise;

   morse_tick_gen #(
      .TICK_COUNT (TICK_COUNT)
   ) u_tick_gen (
      .clock       (clock),
      .reset_n     (reset_n),
      .i_enable    (i_enable),
      .i_half_load (w_half_load),
      .o_tick      (w_tick)
   );

   assign w_mark_ok = (r_mcnt == MARK_DOT) || (r_mcnt == MARK_DASH);
   assign w_full    = (r_nsym == MAX_SYMS);
   assign w_sym_bit = (r_mcnt == MARK_DASH) ? DASH : DOT;
   assign w_dec     = decode_letter(r_nsym, r_sym);

   // Letter FSM with registered result pulses.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state        <= IDLE;
         r_mcnt         <= '0;
         r_scnt         <= '0;
         r_sym          <= '0;
         r_nsym         <= '0;
         r_err          <= 1'b0;
         r_letter       <= LETTER_S;
         r_letter_valid <= 1'b0;
         r_letter_error <= 1'b0;
      end else begin
         r_letter_valid <= 1'b0;
         r_letter_error <= 1'b0;
         if (i_enable) begin
            unique case (r_state)
               IDLE: begin
                  if (w_rise) begin
                     r_state <= MARK;
                     r_mcnt  <= '0;
                     r_sym   <= '0;
                     r_nsym  <= '0;
                     r_err   <= 1'b0;
                  end
               end
               MARK: begin
                  if (w_tick) begin
                     if (r_key_s) begin
                        if (r_mcnt != MARK_SAT) r_mcnt <= r_mcnt + 3'd1;
                     end else begin
                        // Mark closed: only clean dots/dashes fit in the register.
                        r_state <= SPACE;
                        r_scnt  <= 2'd1;
                        if (!w_mark_ok || w_full) r_err <= 1'b1;
                        if (w_mark_ok && !w_full) begin
                           r_sym  <= {r_sym[2:0], w_sym_bit};
                           r_nsym <= r_nsym + 3'd1;
                        end
                     end
                  end
               end
               SPACE: begin
                  if (w_tick) begin
                     if (r_key_s && (r_scnt < GAP_LETTER)) begin
                        r_state <= MARK;
                        r_mcnt  <= 3'd1;
                        if (r_scnt == 2'd2) r_err <= 1'b1;
                     end else if (!r_key_s) begin
                        r_scnt <= r_scnt + 2'd1;
                        if (r_scnt == GAP_LETTER - 2'd1) begin
                           r_state <= IDLE;
                           if (w_dec.match && !r_err) begin
                              r_letter       <= w_dec.code;
                              r_letter_valid <= 1'b1;
                           end else begin
                              r_letter_error <= 1'b1;
                           end
                        end
                     end
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign o_rx.letter       = r_letter;
   assign o_rx.letter_valid = r_letter_valid;
   assign o_rx.letter_error = r_letter_error;
   assign o_rx.busy         = (r_state != IDLE);

endmodule

// File: tb/tb_morse_receiver.sv
// Self-checking bench for morse_receiver: table of letters plus hand-written
// reset and enable sequences, results checked through an expectation queue.
module tb_morse_receiver;

   localparam int TC = 8;

   typedef struct packed {
      logic [2:0]  n;
      logic [14:0] marks;   // mark i (units) at [3*i +: 3]
      logic        err;
      logic [2:0]  code;
   } vec_t;

   typedef struct packed {
      logic       err;
      logic [2:0] code;
   } exp_t;

   logic clock = 1'b0;
   logic reset_n;
   logic enable;
   logic key_in;

   morse_receiver_if rx ();

   morse_receiver #(
      .TICK_COUNT (TC)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .i_enable (enable),
      .i_key_in (key_in),
      .o_rx     (rx)
   );

   always #5 clock = ~clock;

   int         n_checks = 0;
   int         n_errors = 0;
   int         n_pulses = 0;
   exp_t       exp_q[$];
   logic [2:0] model_letter;
   vec_t       vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input int n, input int m0, input int m1, input int m2,
                               input int m3, input int m4, input bit err, input int code);
      vec_t v;
      v.n     = 3'(n);
      v.marks = {3'(m4), 3'(m3), 3'(m2), 3'(m1), 3'(m0)};
      v.err   = err;
      v.code  = 3'(code);
      return v;
   endfunction

   // Model of the letter register: errors leave it unchanged.
   task automatic expect_letter(input bit err, input logic [2:0] code);
      exp_t e;
      if (!err) model_letter = code;
      e.err  = err;
      e.code = model_letter;
      exp_q.push_back(e);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic lvl, input int units);
      key_in = lvl;
      cycles(units * TC);
   endtask

   task automatic send_vec(input vec_t v);
      for (int k = 0; k < int'(v.n); k++) begin
         drive(1'b1, int'(v.marks[3*k +: 3]));
         drive(1'b0, (k == int'(v.n) - 1) ? 4 : 1);
      end
   endtask

   task automatic wait_drain(input string name);
      int budget = 60;
      while (exp_q.size() != 0 && budget > 0) begin
         cycles(1);
         budget--;
      end
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   // Scoreboard: every result pulse must match the oldest expectation.
   always @(negedge clock) begin
      if (reset_n && (rx.letter_valid || rx.letter_error)) begin
         exp_t e;
         n_pulses++;
         check("valid_and_error", 32'(rx.letter_valid && rx.letter_error), 32'd0);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_pulse: valid=%0b error=%0b letter=%0d, expected none",
                     rx.letter_valid, rx.letter_error, rx.letter);
         end else begin
            e = exp_q.pop_front();
            check("pulse_is_error", 32'(rx.letter_error), 32'(e.err));
            check("letter", 32'(rx.letter), 32'(e.code));
         end
      end
   end

   initial begin
      int snap;
      reset_n = 1'b0;
      enable  = 1'b1;
      key_in  = 1'b0;
      model_letter = 3'd0;
      cycles(5);
      check("reset_letter", 32'(rx.letter), 32'd0);
      check("reset_valid", 32'(rx.letter_valid), 32'd0);
      check("reset_error", 32'(rx.letter_error), 32'd0);
      check("reset_busy", 32'(rx.busy), 32'd0);
      reset_n = 1'b1;
      cycles(4);

      vecs[0] = mk(1, 3, 0, 0, 0, 0, 1'b0, 1);   // T
      vecs[1] = mk(3, 1, 1, 1, 0, 0, 1'b0, 0);   // S
      vecs[2] = mk(4, 1, 1, 1, 3, 0, 1'b0, 3);   // V
      vecs[3] = mk(4, 3, 3, 1, 1, 0, 1'b0, 7);   // Z
      vecs[4] = mk(2, 1, 3, 0, 0, 0, 1'b1, 0);   // dot-dash, not in table
      vecs[5] = mk(1, 2, 0, 0, 0, 0, 1'b1, 0);   // 2-unit mark
      vecs[6] = mk(5, 1, 1, 1, 1, 1, 1'b1, 0);   // five dots
      vecs[7] = mk(1, 6, 0, 0, 0, 0, 1'b1, 0);   // key stuck high
      vecs[8] = mk(3, 1, 1, 3, 0, 0, 1'b0, 2);   // U
      vecs[9] = mk(4, 3, 1, 3, 3, 0, 1'b0, 6);   // Y

      for (int i = 0; i < 10; i++) begin
         expect_letter(vecs[i].err, vecs[i].code);
         send_vec(vecs[i]);
         wait_drain($sformatf("drain_vec%0d", i));
         check($sformatf("idle_busy_vec%0d", i), 32'(rx.busy), 32'd0);
      end

      // Reset in the middle of Y, then a clean W.
      drive(1'b1, 3);
      drive(1'b0, 1);
      drive(1'b1, 1);
      drive(1'b0, 1);
      key_in = 1'b1;
      cycles(4);
      snap    = n_pulses;
      key_in  = 1'b0;
      reset_n = 1'b0;
      cycles(3);
      reset_n = 1'b1;
      model_letter = 3'd0;
      cycles(4 * TC);
      check("mid_reset_no_pulse", 32'(n_pulses - snap), 32'd0);
      check("mid_reset_letter", 32'(rx.letter), 32'd0);
      check("mid_reset_busy", 32'(rx.busy), 32'd0);
      expect_letter(1'b0, 3'd4);
      send_vec(mk(3, 1, 3, 3, 0, 0, 1'b0, 4));
      wait_drain("drain_w");

      // Freeze for 20 cycles inside the first dash of X; key held steady.
      expect_letter(1'b0, 3'd5);
      key_in = 1'b1;
      cycles(12);
      snap   = n_pulses;
      enable = 1'b0;
      cycles(20);
      check("frozen_no_pulse", 32'(n_pulses - snap), 32'd0);
      check("frozen_busy", 32'(rx.busy), 32'd1);
      enable = 1'b1;
      cycles(12);
      drive(1'b0, 1);
      drive(1'b1, 1);
      drive(1'b0, 1);
      drive(1'b1, 1);
      drive(1'b0, 1);
      drive(1'b1, 3);
      drive(1'b0, 4);
      wait_drain("drain_x");

      // A key edge while frozen in idle must not start a letter.
      snap   = n_pulses;
      enable = 1'b0;
      key_in = 1'b1;
      cycles(10);
      key_in = 1'b0;
      cycles(10);
      enable = 1'b1;
      cycles(4 * TC);
      check("frozen_edge_busy", 32'(rx.busy), 32'd0);
      check("frozen_edge_no_pulse", 32'(n_pulses - snap), 32'd0);

      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/morse_receiver.md
# morse_receiver

Morse receiver for the lab's 8-letter Morse alphabet (S, T, U, V, W, X, Y, Z → codes 0–7). It samples a serial on/off key line once per Morse unit, measures mark and space run lengths, and classifies each mark as dot or dash. At each letter gap it emits the 3-bit letter code with a one-cycle valid pulse, or an error pulse. It sits at the far end of the Morse LED/serial line, driven by the same unit rate as the transmitter (0.5 s at 50 MHz).

## Interface
- TICK_COUNT, 25_000_000 — clock cycles per Morse unit; ≥ 4.
- clock  in  1  system clock (CLOCK_50)
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  when low, divider and all state hold; key still synchronized
- key_in  in  1  asynchronous Morse line, 1 = mark
- letter  out  3  decoded letter code, held until next valid
- letter_valid  out  1  one-cycle pulse, letter updated this cycle
- letter_error  out  1  one-cycle pulse, malformed/unknown letter
- busy  out  1  high whenever state ≠ IDLE

## Operation
- key_in passes through a 2-flop synchronizer → key_s. All decisions use key_s.
- Tick generator: a down-counter that emits a one-cycle tick on reaching 0, then reloads TICK_COUNT−1. In IDLE, a rising edge of key_s loads TICK_COUNT/2, so that ticks land mid-unit.
- Symbol encoding: dot = 0, dash = 1. The shift register sym[3:0] shifts left, with the new symbol entering bit 0. nsym[2:0] holds the symbol count.
- Mark run counter mcnt saturates at 4. Space run counter scnt saturates at 3. err_flag is sticky per letter.
- States and transitions (evaluated only on tick, except IDLE entry):
  - IDLE → MARK on a key_s rising edge. On entry, set mcnt=0, sym=0, nsym=0, err_flag=0.
  - MARK: on tick with key_s=1, increment mcnt.
  - MARK → SPACE on tick with key_s=0. Close the mark:
    - mcnt=1 → dot.
    - mcnt=3 → dash.
    - mcnt=2 or 4 → set err_flag.
    - If nsym=4 when a fifth symbol closes, set err_flag. Otherwise shift in the symbol and increment nsym.
    - Set scnt=1.
  - SPACE → MARK on tick with key_s=1 and scnt<3: intra-letter gap; set mcnt=1.
    - scnt=2 at that point sets err_flag (an invalid 2-unit gap).
  - SPACE: on tick with key_s=0, increment scnt. When scnt reaches 3, finish the letter and go to IDLE.
- Decode at letter finish, keyed on (nsym, sym[nsym−1:0]):
  - S (3, 000) → 0
  - T (1, 1) → 1
  - U (3, 001) → 2
  - V (4, 0001) → 3
  - W (3, 011) → 4
  - X (4, 1001) → 5
  - Y (4, 1011) → 6
  - Z (4, 1100) → 7
- Finish outcome: on a match with err_flag=0, load letter and pulse letter_valid. Otherwise pulse letter_error and leave letter unchanged.
- Key stuck high: stays in MARK with mcnt saturated at 4. The error is reported when the key drops and a 3-unit space follows.

## Timing
- Reset values: letter=0, letter_valid=0, letter_error=0, busy=0, state=IDLE, divider=TICK_COUNT−1.
- Reset asserted mid-letter discards the partial letter and emits no pulse.
- Synchronizer latency is 2 cycles. busy rises 1 cycle after the key_s rising edge.
- letter_valid / letter_error are registered: high exactly one cycle, in the cycle after the tick on which scnt reaches 3. They are never high together.
- Letter reported 3 units + ≤ 1 unit phase + 3 cycles after the final mark ends.
- enable low freezes the divider, state and counters. Edges seen while frozen in IDLE are ignored.

## Structure
- Package morse_pkg holds:
  - letter code localparams (S=0 … Z=7)
  - DOT/DASH encodings
  - unit constants MARK_DOT=1, MARK_DASH=3, GAP_LETTER=3
  - state enum {IDLE, MARK, SPACE}
  - default TICK_COUNT
- One sub-module, morse_tick_gen: the divider with enable, reset_n, a half-load strobe and the tick output.

## Test plan
- TICK_COUNT=8. Drive T (dash, 3 units at 8 cycles each) then 3+ units low → letter=1, one letter_valid pulse, busy returns low.
- Drive S, then V, then Z back-to-back with 3-unit gaps → letter sequence 0, 3, 7, with exactly three valid pulses.
- Drive dot-dash (A, not in table) → letter_error once; letter holds its previous value.
- Drive a 2-unit mark; separately, five dots → letter_error each time, no letter_valid.
- Assert reset_n=0 mid-Y, then send W → no pulse for Y, letter=4 valid.
- Drop enable for 20 cycles mid-X → X is decoded correctly (letter=5) once enable returns; no spurious pulses occur while frozen.
